// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, drives the instruction
//                SRAM read port and hands {ce, pc} to decode. A branch redirect
//                that arrives while fetch is stalled is latched and replayed
//                when the stall releases.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
   parameter int          STALL_W  = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic [32:0]        br_bus,
   output logic [32:0]        if_to_id_bus,
   output logic               inst_sram_en,
   output logic [3:0]         inst_sram_wen,
   output logic [31:0]        inst_sram_addr,
   output logic [31:0]        inst_sram_wdata,
   output logic [31:0]        fetch_cnt,
   output logic               redir_pending
);

   // IDLE: nothing fetched yet; RUN: fetching; HOLD: redirect latched under stall
   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_HOLD = 2'd2;

   // PC value held during reset so the first increment-free step lands on RESET_PC
   localparam logic [31:0] c_PC_INIT = RESET_PC - 32'd4;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [31:0] r_pc;
   logic        r_pend;
   logic [31:0] r_pend_addr;
   logic [31:0] r_fetch_cnt;
   logic        w_ce;
   logic        w_stall;
   logic        w_br_e;
   logic [31:0] w_br_addr;
   logic [31:0] w_next_pc;
   logic        w_unused;

   assign w_stall   = stall[0];
   assign w_br_e    = br_bus[32];
   assign w_br_addr = br_bus[31:0];

   // Upper stall bits belong to later pipeline stages
   assign w_unused  = ^stall[STALL_W-1:1];

   // A latched redirect is older than anything decode presents now, so it wins
   assign w_next_pc = r_pend ? r_pend_addr :
                      w_br_e ? w_br_addr   : r_pc + 32'd4;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: leave IDLE unconditionally, park in HOLD while a redirect waits
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  w_state_nxt = c_RUN;
         c_RUN:   if (w_stall && w_br_e) w_state_nxt = c_HOLD;
         c_HOLD:  if (!w_stall) w_state_nxt = c_RUN;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Output decode: fetch is enabled in every state except IDLE
   always_comb begin
      w_ce = 1'b0;
      case (r_state)
         c_RUN,
         c_HOLD:  w_ce = 1'b1;
         default: w_ce = 1'b0;
      endcase
   end

   // PC, pending redirect and fetch counter datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc        <= c_PC_INIT;
         r_pend      <= 1'b0;
         r_pend_addr <= 32'd0;
         r_fetch_cnt <= 32'd0;
      end else begin
         case (r_state)
            c_IDLE: begin
               r_pc <= RESET_PC;
            end
            c_RUN: begin
               if (!w_stall) begin
                  r_pc        <= w_next_pc;
                  r_fetch_cnt <= r_fetch_cnt + 32'd1;
               end else if (w_br_e) begin
                  r_pend      <= 1'b1;
                  r_pend_addr <= w_br_addr;
               end
            end
            c_HOLD: begin
               if (w_stall) begin
                  // Decode re-presents its branch each stalled cycle; keep the latest
                  if (w_br_e) r_pend_addr <= w_br_addr;
               end else begin
                  r_pc        <= w_next_pc;
                  r_pend      <= 1'b0;
                  r_fetch_cnt <= r_fetch_cnt + 32'd1;
               end
            end
            default: begin
               r_pend <= 1'b0;
            end
         endcase
      end
   end

   // Outputs come from registers only; the decode bus reads all-zero until fetch starts
   assign inst_sram_en    = w_ce;
   assign inst_sram_wen   = 4'b0000;
   assign inst_sram_addr  = r_pc;
   assign inst_sram_wdata = 32'd0;
   assign if_to_id_bus    = w_ce ? {1'b1, r_pc} : 33'd0;
   assign fetch_cnt       = r_fetch_cnt;
   assign redir_pending   = r_pend;

endmodule
`default_nettype wire
